cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameters: none; widths are fixed by the 6-bit address, 8-bit data, 2-bit opcode datapath.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_code  input  2  datapath IR[7:6]; 00 LDA, 01 STA, 10 ADD, 11 JMP.
REQ-005 mem_ready  input  1  memory handshake; 1 = read data valid on data_bus, or write accepted, this cycle.
REQ-006 pc_on_adr, ir_on_adr  output  1 each  address-bus source selects; never both 1.
REQ-007 data_on_dbus, alu_on_dbus  output  1 each  internal dbus source selects; never both 1.
REQ-008 dbus_on_data  output  1  drive internal dbus onto external data_bus.
REQ-009 ld_ir, ld_ac, ld_pc, inc_pc, clr_pc  output  1 each  datapath register controls.
REQ-010 pass, add  output  1 each  ALU function selects; never both 1.
REQ-011 rd_mem, wr_mem  output  1 each  memory read/write strobes; never both 1.

Function
REQ-012 The controller is a Moore/Mealy FSM with states RST, FETCH, DECODE, EX_LDA, EX_STA, EX_ADD, EX_JMP.
REQ-013 Every output that is not listed as asserted for the current state is 0.
REQ-014 RST: assert clr_pc; next state FETCH.
REQ-015 FETCH: assert pc_on_adr, rd_mem, data_on_dbus; assert ld_ir and inc_pc only in the cycle mem_ready=1; stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-016 DECODE: one cycle, no outputs; next state from op_code: 00->EX_LDA, 01->EX_STA, 10->EX_ADD, 11->EX_JMP.
REQ-017 EX_LDA: assert ir_on_adr, rd_mem, data_on_dbus; assert ld_ac only when mem_ready=1; wait while mem_ready=0; then FETCH.
REQ-018 EX_STA: assert ir_on_adr, pass, alu_on_dbus, dbus_on_data, wr_mem; wait while mem_ready=0; FETCH when mem_ready=1.
REQ-019 EX_ADD: one cycle, no memory access; assert add, alu_on_dbus, ld_ac; next FETCH.
REQ-020 EX_JMP: one cycle; assert ld_pc; next FETCH.
REQ-021 Instruction latency with zero-wait memory: LDA/STA 3 cycles, ADD/JMP 3 cycles (FETCH, DECODE, EX).
REQ-022 Each wait cycle with mem_ready=0 adds exactly one cycle; no timeout, no abort.
REQ-023 mem_ready is ignored in RST, DECODE, EX_ADD, EX_JMP.
REQ-024 pc and ir load/increment strobes are each at most one cycle per instruction.

Reset
REQ-025 reset=1 at a rising edge forces state RST next cycle, overriding any state including mid-wait in FETCH/EX_LDA/EX_STA.
REQ-026 While in RST, all outputs other than clr_pc are 0, so no bus is driven and no strobe is active.
REQ-027 Held reset keeps the FSM in RST with clr_pc=1; first FETCH occurs the cycle after reset deasserts.

Structure
REQ-028 Shared package holds the state enumeration and the opcode constants OP_LDA=00, OP_STA=01, OP_ADD=10, OP_JMP=11.
REQ-029 Single module; state register plus combinational next-state/output logic; no sub-module.
REQ-030 A top-level cpu wrapper connects cpu_controller outputs one-to-one to the same-named datapath control inputs.

Verification
REQ-031 reset 1 for 2 cycles then 0, mem_ready=1 -> clr_pc=1 during reset cycles, then pc_on_adr=rd_mem=ld_ir=inc_pc=1 next cycle.
REQ-032 FETCH with mem_ready=0 for 3 cycles then 1 -> rd_mem held 4 cycles, ld_ir/inc_pc high only in 4th, DECODE follows.
REQ-033 op_code=10 after fetch -> EX_ADD cycle shows add=alu_on_dbus=ld_ac=1, rd_mem=wr_mem=0, FETCH next.
REQ-034 op_code=01, mem_ready low 2 cycles -> wr_mem, dbus_on_data, pass, ir_on_adr held 3 cycles, then FETCH.
REQ-035 op_code=11 -> single cycle ld_pc=1, inc_pc=0, then FETCH with pc_on_adr=1.
REQ-036 reset asserted during EX_LDA wait -> next cycle RST, rd_mem=0, ld_ac never pulsed; all exclusivity checks (REQ-006/007/010/011) pass every cycle.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// Shared types for the accumulator CPU control path: FSM states and opcode encodings.
package cpu_controller_pkg;

    typedef enum logic [2:0] {
        RST,
        FETCH,
        DECODE,
        EX_LDA,
        EX_STA,
        EX_ADD,
        EX_JMP
    } state_t;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_STA = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

endpackage

// File: rtl/cpu_controller.sv
// Instruction sequencer for the accumulator CPU: fetch/decode/execute with memory wait states.
// Load strobes are Mealy on mem_ready; a wait cycle simply holds the current state.
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op_code,
    input  logic       mem_ready,
    output logic       pc_on_adr,
    output logic       ir_on_adr,
    output logic       data_on_dbus,
    output logic       alu_on_dbus,
    output logic       dbus_on_data,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       clr_pc,
    output logic       pass,
    output logic       add,
    output logic       rd_mem,
    output logic       wr_mem
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_on_adr    = 1'b0;
        ir_on_adr    = 1'b0;
        data_on_dbus = 1'b0;
        alu_on_dbus  = 1'b0;
        dbus_on_data = 1'b0;
        ld_ir        = 1'b0;
        ld_ac        = 1'b0;
        ld_pc        = 1'b0;
        inc_pc       = 1'b0;
        clr_pc       = 1'b0;
        pass         = 1'b0;
        add          = 1'b0;
        rd_mem       = 1'b0;
        wr_mem       = 1'b0;

        case (state)
            RST: begin
                clr_pc    = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                pc_on_adr    = 1'b1;
                rd_mem       = 1'b1;
                data_on_dbus = 1'b1;
                ld_ir        = mem_ready;
                inc_pc       = mem_ready;
                if (mem_ready) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                case (op_code)
                    OP_LDA:  state_nxt = EX_LDA;
                    OP_STA:  state_nxt = EX_STA;
                    OP_ADD:  state_nxt = EX_ADD;
                    default: state_nxt = EX_JMP;
                endcase
            end
            EX_LDA: begin
                ir_on_adr    = 1'b1;
                rd_mem       = 1'b1;
                data_on_dbus = 1'b1;
                ld_ac        = mem_ready;
                if (mem_ready) begin
                    state_nxt = FETCH;
                end
            end
            EX_STA: begin
                ir_on_adr    = 1'b1;
                pass         = 1'b1;
                alu_on_dbus  = 1'b1;
                dbus_on_data = 1'b1;
                wr_mem       = 1'b1;
                if (mem_ready) begin
                    state_nxt = FETCH;
                end
            end
            EX_ADD: begin
                add         = 1'b1;
                alu_on_dbus = 1'b1;
                ld_ac       = 1'b1;
                state_nxt   = FETCH;
            end
            EX_JMP: begin
                ld_pc     = 1'b1;
                state_nxt = FETCH;
            end
            // Unused encoding recovers through the reset state.
            default: begin
                state_nxt = RST;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed and random bench for cpu_controller against an instruction-step reference model.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] op_code = 2'b00;
    logic       mem_ready = 1'b1;
    logic       pc_on_adr, ir_on_adr, data_on_dbus, alu_on_dbus, dbus_on_data;
    logic       ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, rd_mem, wr_mem;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: is the CPU held in reset, which step of the instruction is running
    // (0 fetch, 1 decode, 2 execute) and which instruction was decoded.
    bit       m_known = 0;
    bit       m_in_reset = 0;
    int       m_step = 0;
    bit [1:0] m_instr = 2'b00;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk(clk), .reset(reset), .op_code(op_code), .mem_ready(mem_ready),
        .pc_on_adr(pc_on_adr), .ir_on_adr(ir_on_adr), .data_on_dbus(data_on_dbus),
        .alu_on_dbus(alu_on_dbus), .dbus_on_data(dbus_on_data), .ld_ir(ld_ir),
        .ld_ac(ld_ac), .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc),
        .pass(pass), .add(add), .rd_mem(rd_mem), .wr_mem(wr_mem)
    );

    // Bit order: pc_on_adr ir_on_adr data_on_dbus alu_on_dbus dbus_on_data ld_ir ld_ac
    //            ld_pc inc_pc clr_pc pass add rd_mem wr_mem
    function automatic logic [13:0] expected_outputs(input bit mr);
        logic [13:0] v;
        v = '0;
        if (m_in_reset) begin
            v[4] = 1'b1;
        end else if (m_step == 0) begin
            v[13] = 1'b1; v[11] = 1'b1; v[1] = 1'b1;
            v[8] = mr; v[5] = mr;
        end else if (m_step == 2) begin
            case (m_instr)
                2'b00: begin v[12] = 1'b1; v[1] = 1'b1; v[11] = 1'b1; v[7] = mr; end
                2'b01: begin v[12] = 1'b1; v[3] = 1'b1; v[10] = 1'b1; v[9] = 1'b1; v[0] = 1'b1; end
                2'b10: begin v[2] = 1'b1; v[10] = 1'b1; v[7] = 1'b1; end
                default: v[6] = 1'b1;
            endcase
        end
        return v;
    endfunction

    function automatic bit memory_instr(input bit [1:0] ins);
        return (ins == 2'b00) || (ins == 2'b01);
    endfunction

    task automatic model_advance(input bit r, input bit mr, input bit [1:0] op);
        if (r) begin
            m_known = 1; m_in_reset = 1;
        end else if (!m_known) begin
            m_known = 0;
        end else if (m_in_reset) begin
            m_in_reset = 0; m_step = 0;
        end else if (m_step == 0) begin
            if (mr) m_step = 1;
        end else if (m_step == 1) begin
            m_instr = op; m_step = 2;
        end else begin
            if (!memory_instr(m_instr) || mr) m_step = 0;
        end
    endtask

    task automatic cycle(input string tag, input bit r, input bit mr, input bit [1:0] op);
        logic [13:0] obs, exp_v;
        bit excl_ok;
        reset = r; mem_ready = mr; op_code = op;
        #2;
        obs = {pc_on_adr, ir_on_adr, data_on_dbus, alu_on_dbus, dbus_on_data, ld_ir, ld_ac,
               ld_pc, inc_pc, clr_pc, pass, add, rd_mem, wr_mem};
        excl_ok = !(pc_on_adr && ir_on_adr) && !(data_on_dbus && alu_on_dbus)
                  && !(pass && add) && !(rd_mem && wr_mem);
        if (m_known) begin
            exp_v = expected_outputs(mr);
            n_checks++;
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
            end
            n_checks++;
            assert (excl_ok === 1'b1) else begin
                n_fail++;
                $error("FAIL %s_exclusive: observed %b expected 1", tag, excl_ok);
            end
        end
        @(posedge clk);
        model_advance(r, mr, op);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset for two cycles, then release with zero-wait memory.
        cycle("rst0", 1, 1, 2'b00);
        cycle("rst1", 1, 1, 2'b00);
        cycle("rst_state", 0, 1, 2'b10);
        cycle("fetch_first", 0, 1, 2'b10);
        cycle("decode_add", 0, 1, 2'b10);
        cycle("ex_add", 0, 0, 2'b00);
        // Fetch with three wait cycles, then store with two wait cycles.
        cycle("fetch_wait0", 0, 0, 2'b01);
        cycle("fetch_wait1", 0, 0, 2'b01);
        cycle("fetch_wait2", 0, 0, 2'b01);
        cycle("fetch_done", 0, 1, 2'b01);
        cycle("decode_sta", 0, 1, 2'b01);
        cycle("sta_wait0", 0, 0, 2'b00);
        cycle("sta_wait1", 0, 0, 2'b00);
        cycle("sta_done", 0, 1, 2'b00);
        // Jump, then the following fetch.
        cycle("fetch_jmp", 0, 1, 2'b11);
        cycle("decode_jmp", 0, 1, 2'b11);
        cycle("ex_jmp", 0, 1, 2'b00);
        cycle("fetch_after_jmp", 0, 1, 2'b00);
        // Reset asserted while a load waits on memory.
        cycle("decode_lda", 0, 1, 2'b00);
        cycle("lda_wait0", 0, 0, 2'b00);
        cycle("lda_wait_rst", 1, 0, 2'b00);
        cycle("rst_after_lda", 0, 1, 2'b00);
        cycle("fetch_after_rst", 0, 1, 2'b01);
        // Random instruction streams with random wait states and occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle("random", ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0),
                  2'($urandom_range(0, 3)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
